lat_recorder: RTL

- Downstream consumer of the read engine's per-request latency samples (lat_timer / lat_timer_valid).
- Captures each sample into an on-chip buffer and keeps running count, min, max and sum.
- The host can read the results after a run, and an external analyser can read them while a run is in progress.
- Sits between the read engine and the host status/register path.

---
 rtl/lat_recorder.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/lat_recorder.sv
// Latency sample recorder: captures read-engine latency samples into an on-chip
// buffer and keeps running count/min/max/sum statistics for host and analyser.
module lat_recorder #(
   parameter int LAT_WIDTH  = 16,
   parameter int DEPTH_LOG2 = 10,
   parameter int CNT_WIDTH  = 32,
   parameter int SUM_WIDTH  = 48
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  end_of_exec,
   input  logic                  lat_timer_valid,
   input  logic [LAT_WIDTH-1:0]  lat_timer,
   input  logic                  rd_req,
   input  logic [DEPTH_LOG2-1:0] rd_idx,
   output logic                  rd_valid,
   output logic [LAT_WIDTH-1:0]  rd_data,
   output logic [CNT_WIDTH-1:0]  sample_cnt,
   output logic [DEPTH_LOG2:0]   stored_cnt,
   output logic [LAT_WIDTH-1:0]  lat_min,
   output logic [LAT_WIDTH-1:0]  lat_max,
   output logic [SUM_WIDTH-1:0]  lat_sum,
   output logic                  overflow,
   output logic                  busy,
   output logic                  done
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_CNT = DEPTH[DEPTH_LOG2:0];

   if (SUM_WIDTH < LAT_WIDTH + CNT_WIDTH) begin : g_bad_sum_width
      $error("lat_recorder: SUM_WIDTH must be >= LAT_WIDTH + CNT_WIDTH");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [LAT_WIDTH-1:0]  r_mem [DEPTH];
   logic [LAT_WIDTH-1:0]  r_rd_q;
   logic                  r_rd_hit;
   logic                  r_rd_valid;

   logic [CNT_WIDTH-1:0]  r_sample_cnt;
   logic [DEPTH_LOG2:0]   r_stored_cnt;
   logic [LAT_WIDTH-1:0]  r_min;
   logic [LAT_WIDTH-1:0]  r_max;
   logic [SUM_WIDTH-1:0]  r_sum;
   logic                  r_overflow;

   logic                  w_capture;
   logic                  w_room;
   logic                  w_wr;
   logic                  w_rd_in_range;

   // ---------------------------------------------------------------------------
   // Run-control FSM
   // ---------------------------------------------------------------------------
   // NOTE: state and all other flops use non-blocking assignments so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // NOTE: next state gets a default before the case so no path infers a latch.
   always_comb begin
      w_state_nxt = r_state;
      if (start) begin
         w_state_nxt = S_ARMED;
      end else begin
         case (r_state)
            S_ARMED: if (end_of_exec) w_state_nxt = S_DONE;
            S_IDLE,
            S_DONE:  w_state_nxt = r_state;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   assign busy = (r_state == S_ARMED);
   assign done = (r_state == S_DONE);

   // ---------------------------------------------------------------------------
   // Capture qualification: start always wins over a coincident sample
   // ---------------------------------------------------------------------------
   assign w_capture = (r_state == S_ARMED) && lat_timer_valid && !start;
   assign w_room    = (r_stored_cnt < DEPTH_CNT);
   assign w_wr      = w_capture && w_room;

   // ---------------------------------------------------------------------------
   // Running statistics
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sample_cnt <= '0;
         r_stored_cnt <= '0;
         r_min        <= '1;
         r_max        <= '0;
         r_sum        <= '0;
         r_overflow   <= 1'b0;
      end else if (start) begin
         r_sample_cnt <= '0;
         r_stored_cnt <= '0;
         r_min        <= '1;
         r_max        <= '0;
         r_sum        <= '0;
         r_overflow   <= 1'b0;
      end else if (w_capture) begin
         if (r_sample_cnt != '1) begin
            r_sample_cnt <= r_sample_cnt + 1'b1;
         end
         if (w_room) begin
            r_stored_cnt <= r_stored_cnt + 1'b1;
         end else begin
            r_overflow <= 1'b1;
         end
         if (lat_timer < r_min) begin
            r_min <= lat_timer;
         end
         if (lat_timer > r_max) begin
            r_max <= lat_timer;
         end
         r_sum <= r_sum + SUM_WIDTH'(lat_timer);
      end
   end

   assign sample_cnt = r_sample_cnt;
   assign stored_cnt = r_stored_cnt;
   assign lat_min    = r_min;
   assign lat_max    = r_max;
   assign lat_sum    = r_sum;
   assign overflow   = r_overflow;

   // ---------------------------------------------------------------------------
   // Sample buffer: simple dual-port RAM, one write port, one registered read
   // ---------------------------------------------------------------------------
   // NOTE: the RAM array and its read register carry no reset so they map onto
   // block RAM; the reset-visible read result is handled by r_rd_hit instead.
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_stored_cnt[DEPTH_LOG2-1:0]] <= lat_timer;
      end
   end

   always_ff @(posedge clk) begin
      if (rd_req) begin
         r_rd_q <= r_mem[rd_idx];
      end
   end

   // Range is judged against the stored count at request time.
   assign w_rd_in_range = ({1'b0, rd_idx} < r_stored_cnt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_valid <= 1'b0;
         r_rd_hit   <= 1'b0;
      end else begin
         r_rd_valid <= rd_req;
         if (rd_req) begin
            r_rd_hit <= w_rd_in_range;
         end
      end
   end

   // Both r_rd_hit and r_rd_q hold between requests, so rd_data holds too.
   assign rd_valid = r_rd_valid;
   assign rd_data  = r_rd_hit ? r_rd_q : '0;

endmodule
